// File: rtl/nfc_cmd_pkg.sv
// Shared constants for the NFC command dispatcher and its helpers:
// FSM encodings, ACG slice widths and the idle-time ACG request.
package nfc_cmd_pkg;

  localparam int CMD_W = 8;
  localparam int OPT_W = 3;
  localparam int NOD_W = 16;
  localparam int CAD_W = 40;

  // One-hot so a checker can assert $onehot(state) directly.
  localparam logic [2:0] ST_IDLE   = 3'b001;
  localparam logic [2:0] ST_ACTIVE = 3'b010;
  localparam logic [2:0] ST_FINISH = 3'b100;

  localparam logic [CMD_W-1:0] ACG_CMD_DEFAULT   = 8'h00;
  localparam logic [OPT_W-1:0] ACG_OPT_DEFAULT   = 3'b000;
  localparam logic [NOD_W-1:0] ACG_NOD_DEFAULT   = 16'h0000;
  localparam logic             ACG_CASEL_DEFAULT = 1'b1;
  localparam logic [CAD_W-1:0] ACG_CAD_DEFAULT   = 40'h0;

endpackage

// File: rtl/nfc_onehot_prio_enc.sv
// Fixed-priority encoder: one-hot grant of the lowest set request bit,
// plus a flag raised when more than one request bit is set.
module nfc_onehot_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         multi
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    multi = |(req & ~grant);
  end

endmodule

// File: rtl/nfc_command_dispatcher.sv
// Shares one atomic command generator between several NFC command modules:
// gates host commands, latches the claiming module and muxes its ACG request.
module nfc_command_dispatcher
  import nfc_cmd_pkg::*;
#(
  parameter int NumberOfWays  = 4,
  parameter int NumOfModules  = 4,
  parameter int TimeoutCycles = 2**20
) (
  input  logic                                 iSystemClock,
  input  logic                                 iReset,
  input  logic                                 iCMDValid,
  output logic                                 oCMDReady,
  output logic                                 oModCMDValid,
  input  logic [NumOfModules-1:0]              iModCMDReady,
  input  logic [NumOfModules-1:0]              iModStart,
  input  logic [NumOfModules-1:0]              iModLastStep,
  input  logic [CMD_W*NumOfModules-1:0]        iModACG_Command,
  input  logic [OPT_W*NumOfModules-1:0]        iModACG_CmdOption,
  input  logic [NumberOfWays*NumOfModules-1:0] iModACG_TargetWay,
  input  logic [NOD_W*NumOfModules-1:0]        iModACG_NumOfData,
  input  logic [NumOfModules-1:0]              iModACG_CASelect,
  input  logic [CAD_W*NumOfModules-1:0]        iModACG_CAData,
  output logic [CMD_W-1:0]                     oACG_Command,
  output logic [OPT_W-1:0]                     oACG_CommandOption,
  output logic [NumberOfWays-1:0]              oACG_TargetWay,
  output logic [NOD_W-1:0]                     oACG_NumOfData,
  output logic                                 oACG_CASelect,
  output logic [CAD_W-1:0]                     oACG_CAData,
  output logic [NumOfModules-1:0]              oOwner,
  output logic                                 oBusy,
  output logic                                 oLastStep,
  output logic                                 oTimeout,
  output logic                                 oError,
  output logic [2:0]                           debug_state
);

  localparam logic [31:0] WD_LIMIT = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);

  logic [2:0]              state;
  logic [NumOfModules-1:0] owner;
  logic [31:0]             watchdog;
  logic                    last_q;
  logic                    timeout_q;
  logic                    error_q;
  logic [NumOfModules-1:0] grant;
  logic                    multi;
  logic                    is_idle;
  logic                    is_active;
  logic                    accept;
  logic                    owner_last;
  logic                    wd_expire;

  nfc_onehot_prio_enc #(.N(NumOfModules)) u_prio (
    .req   (iModStart),
    .grant (grant),
    .multi (multi)
  );

  assign is_idle    = (state == ST_IDLE);
  assign is_active  = (state == ST_ACTIVE);
  assign accept     = is_idle && iCMDValid && (|iModStart);
  assign owner_last = |(iModLastStep & owner);
  assign wd_expire  = (TimeoutCycles != 0) && (watchdog == WD_LIMIT);

  // Handshake: the host transfer happens when iCMDValid && oCMDReady; the
  // modules only see a valid command while the dispatcher is IDLE.
  assign oCMDReady    = is_idle && (&iModCMDReady);
  assign oModCMDValid = iCMDValid && is_idle;

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      watchdog  <= '0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      last_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_ACTIVE;
            owner     <= grant;
            error_q   <= multi;
            watchdog  <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (watchdog != '1) watchdog <= watchdog + 32'd1;
          // LastStep takes precedence over a watchdog expiry in the same cycle.
          if (owner_last) begin
            state  <= ST_FINISH;
            last_q <= 1'b1;
          end else if (wd_expire) begin
            state     <= ST_FINISH;
            timeout_q <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          owner <= '0;
        end
        default: begin
          state <= ST_IDLE;
          owner <= '0;
        end
      endcase
    end
  end

  assign oOwner      = owner;
  assign oBusy       = !is_idle;
  assign oLastStep   = last_q;
  assign oTimeout    = timeout_q;
  assign oError      = error_q;
  assign debug_state = state;

  // AND-OR mux over the one-hot owner; only meaningful while ACTIVE.
  logic [CMD_W-1:0]        cmd_m [NumOfModules];
  logic [OPT_W-1:0]        opt_m [NumOfModules];
  logic [NumberOfWays-1:0] way_m [NumOfModules];
  logic [NOD_W-1:0]        nod_m [NumOfModules];
  logic                    cas_m [NumOfModules];
  logic [CAD_W-1:0]        cad_m [NumOfModules];

  genvar k;
  generate
    for (k = 0; k < NumOfModules; k++) begin : g_slice
      assign cmd_m[k] = iModACG_Command[k*CMD_W +: CMD_W] & {CMD_W{owner[k]}};
      assign opt_m[k] = iModACG_CmdOption[k*OPT_W +: OPT_W] & {OPT_W{owner[k]}};
      assign way_m[k] = iModACG_TargetWay[k*NumberOfWays +: NumberOfWays] & {NumberOfWays{owner[k]}};
      assign nod_m[k] = iModACG_NumOfData[k*NOD_W +: NOD_W] & {NOD_W{owner[k]}};
      assign cas_m[k] = iModACG_CASelect[k] & owner[k];
      assign cad_m[k] = iModACG_CAData[k*CAD_W +: CAD_W] & {CAD_W{owner[k]}};
    end
  endgenerate

  logic [CMD_W-1:0]        cmd_or;
  logic [OPT_W-1:0]        opt_or;
  logic [NumberOfWays-1:0] way_or;
  logic [NOD_W-1:0]        nod_or;
  logic                    cas_or;
  logic [CAD_W-1:0]        cad_or;

  always_comb begin
    cmd_or = '0;
    opt_or = '0;
    way_or = '0;
    nod_or = '0;
    cas_or = 1'b0;
    cad_or = '0;
    for (int i = 0; i < NumOfModules; i++) begin
      cmd_or = cmd_or | cmd_m[i];
      opt_or = opt_or | opt_m[i];
      way_or = way_or | way_m[i];
      nod_or = nod_or | nod_m[i];
      cas_or = cas_or | cas_m[i];
      cad_or = cad_or | cad_m[i];
    end
  end

  assign oACG_Command       = is_active ? cmd_or : ACG_CMD_DEFAULT;
  assign oACG_CommandOption = is_active ? opt_or : ACG_OPT_DEFAULT;
  assign oACG_TargetWay     = is_active ? way_or : '0;
  assign oACG_NumOfData     = is_active ? nod_or : ACG_NOD_DEFAULT;
  assign oACG_CASelect      = is_active ? cas_or : ACG_CASEL_DEFAULT;
  assign oACG_CAData        = is_active ? cad_or : ACG_CAD_DEFAULT;

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// Self-checking bench for nfc_command_dispatcher: directed scenarios with an
// owner scoreboard and a watchdog limit of 16 cycles.
module tb_nfc_command_dispatcher;

  localparam int W  = 4;
  localparam int M  = 4;
  localparam int TO = 16;

  localparam logic [2:0] S_IDLE   = 3'b001;
  localparam logic [2:0] S_ACTIVE = 3'b010;
  localparam logic [2:0] S_FINISH = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          mod_cmd_valid;
  logic [M-1:0]  mod_ready;
  logic [M-1:0]  mod_start;
  logic [M-1:0]  mod_last;
  logic [8*M-1:0]  f_cmd;
  logic [3*M-1:0]  f_opt;
  logic [W*M-1:0]  f_way;
  logic [16*M-1:0] f_nod;
  logic [M-1:0]    f_cas;
  logic [40*M-1:0] f_cad;
  logic [7:0]    acg_cmd;
  logic [2:0]    acg_opt;
  logic [W-1:0]  acg_way;
  logic [15:0]   acg_nod;
  logic          acg_cas;
  logic [39:0]   acg_cad;
  logic [M-1:0]  owner;
  logic          busy;
  logic          last_step;
  logic          timeout;
  logic          error;
  logic [2:0]    dbg_state;

  logic [7:0]  s_cmd [M];
  logic [2:0]  s_opt [M];
  logic [W-1:0] s_way [M];
  logic [15:0] s_nod [M];
  logic        s_cas [M];
  logic [39:0] s_cad [M];

  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      f_cmd[i*8 +: 8]   = s_cmd[i];
      f_opt[i*3 +: 3]   = s_opt[i];
      f_way[i*W +: W]   = s_way[i];
      f_nod[i*16 +: 16] = s_nod[i];
      f_cas[i]          = s_cas[i];
      f_cad[i*40 +: 40] = s_cad[i];
    end
  end

  nfc_command_dispatcher #(
    .NumberOfWays (W),
    .NumOfModules (M),
    .TimeoutCycles(TO)
  ) dut (
    .iSystemClock      (clk),
    .iReset            (rst),
    .iCMDValid         (cmd_valid),
    .oCMDReady         (cmd_ready),
    .oModCMDValid      (mod_cmd_valid),
    .iModCMDReady      (mod_ready),
    .iModStart         (mod_start),
    .iModLastStep      (mod_last),
    .iModACG_Command   (f_cmd),
    .iModACG_CmdOption (f_opt),
    .iModACG_TargetWay (f_way),
    .iModACG_NumOfData (f_nod),
    .iModACG_CASelect  (f_cas),
    .iModACG_CAData    (f_cad),
    .oACG_Command      (acg_cmd),
    .oACG_CommandOption(acg_opt),
    .oACG_TargetWay    (acg_way),
    .oACG_NumOfData    (acg_nod),
    .oACG_CASelect     (acg_cas),
    .oACG_CAData       (acg_cad),
    .oOwner            (owner),
    .oBusy             (busy),
    .oLastStep         (last_step),
    .oTimeout          (timeout),
    .oError            (error),
    .debug_state       (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow a further #1.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_acg_default(input string tag);
    check({tag, "_cmd"}, acg_cmd, 8'h00);
    check({tag, "_opt"}, acg_opt, 3'd0);
    check({tag, "_way"}, acg_way, 4'd0);
    check({tag, "_nod"}, acg_nod, 16'd0);
    check({tag, "_cas"}, acg_cas, 1'b1);
    check({tag, "_cad"}, acg_cad, 40'h0);
  endtask

  task automatic check_acg_slice(input string tag, input int k);
    check({tag, "_cmd"}, acg_cmd, s_cmd[k]);
    check({tag, "_opt"}, acg_opt, s_opt[k]);
    check({tag, "_way"}, acg_way, s_way[k]);
    check({tag, "_nod"}, acg_nod, s_nod[k]);
    check({tag, "_cas"}, acg_cas, s_cas[k]);
    check({tag, "_cad"}, acg_cad, s_cad[k]);
  endtask

  task automatic accept(input logic [3:0] start, input logic [3:0] exp_owner, input logic exp_err);
    exp_q.push_back(exp_owner);
    cmd_valid = 1'b1;
    mod_start = start;
    #1;
    check("mod_cmd_valid_idle", mod_cmd_valid, 1'b1);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    next_cycle();
    cmd_valid = 1'b0;
    mod_start = '0;
    #1;
    check("owner", owner, exp_q.pop_front());
    check("busy_active", busy, 1'b1);
    check("state_active", dbg_state, S_ACTIVE);
    check("error_pulse", error, exp_err);
    check("cmd_ready_busy", cmd_ready, 1'b0);
  endtask

  task automatic finish_cmd(input int k);
    mod_last = 4'b0001 << k;
    next_cycle();
    mod_last = '0;
    #1;
    check("last_step_pulse", last_step, 1'b1);
    check("state_finish", dbg_state, S_FINISH);
    check_acg_default("acg_finish");
    next_cycle();
    #1;
    check("last_step_clear", last_step, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("owner_idle", owner, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int err_cnt;
    int hold;

    s_cmd = '{8'h11, 8'h40, 8'hA2, 8'h33};
    s_opt = '{3'd1, 3'd5, 3'd2, 3'd7};
    s_way = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    s_nod = '{16'h0101, 16'h1234, 16'hBEEF, 16'h0F0F};
    s_cas = '{1'b0, 1'b0, 1'b0, 1'b0};
    s_cad = '{40'h0000000001, 40'hFF00000000, 40'hAAAAAAAAAA, 40'h1234567890};
    rst = 1'b1;
    cmd_valid = 1'b0;
    mod_ready = '1;
    mod_start = '0;
    mod_last  = '0;

    // Reset
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 4'b0000);
    check("rst_last", last_step, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_mod_cmd_valid", mod_cmd_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_state", dbg_state, S_IDLE);
    check_acg_default("rst_acg");
    mod_ready = 4'b1101;
    #1;
    check("cmd_ready_mod_not_ready", cmd_ready, 1'b0);
    mod_ready = '1;
    next_cycle();

    // Single command on module 1
    accept(4'b0010, 4'b0010, 1'b0);
    check_acg_slice("single_acg", 1);
    hold = $urandom_range(1, 5);
    for (int i = 0; i < hold; i++) next_cycle();
    #1;
    check("single_still_owner", owner, 4'b0010);
    finish_cmd(1);

    // Conflict: modules 0 and 2 start together
    next_cycle();
    accept(4'b0101, 4'b0001, 1'b1);
    err_cnt = int'(error);
    check_acg_slice("conflict_acg", 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      err_cnt += int'(error);
      check("conflict_no_slice2", (acg_cmd == s_cmd[2]), 1'b0);
    end
    check("conflict_error_once", err_cnt, 1);
    finish_cmd(0);

    // Gating while busy
    next_cycle();
    accept(4'b0001, 4'b0001, 1'b0);
    cmd_valid = 1'b1;
    mod_start = 4'b1000;
    mod_last  = 4'b0100;
    #1;
    check("gate_mod_cmd_valid", mod_cmd_valid, 1'b0);
    check("gate_cmd_ready", cmd_ready, 1'b0);
    next_cycle();
    #1;
    check("gate_owner_kept", owner, 4'b0001);
    check("gate_state", dbg_state, S_ACTIVE);
    check("gate_no_last", last_step, 1'b0);
    cmd_valid = 1'b0;
    mod_start = '0;
    mod_last  = '0;
    finish_cmd(0);

    // Watchdog expiry: 16 ACTIVE cycles without LastStep
    next_cycle();
    accept(4'b0010, 4'b0010, 1'b0);
    for (int c = 2; c <= TO; c++) next_cycle();
    #1;
    check("wd_cycle16_active", dbg_state, S_ACTIVE);
    check("wd_cycle16_no_timeout", timeout, 1'b0);
    next_cycle();
    #1;
    check("wd_finish", dbg_state, S_FINISH);
    check("wd_timeout_set", timeout, 1'b1);
    check("wd_no_last", last_step, 1'b0);
    next_cycle();
    #1;
    check("wd_idle", dbg_state, S_IDLE);
    check("wd_timeout_sticky", timeout, 1'b1);
    next_cycle();
    next_cycle();
    #1;
    check("wd_timeout_sticky2", timeout, 1'b1);

    // LastStep on cycle 16 beats the watchdog; accept clears the sticky flag
    accept(4'b0001, 4'b0001, 1'b0);
    check("wd_timeout_cleared", timeout, 1'b0);
    for (int c = 2; c <= TO; c++) next_cycle();
    mod_last = 4'b0001;
    next_cycle();
    mod_last = '0;
    #1;
    check("wd_race_last", last_step, 1'b1);
    check("wd_race_timeout", timeout, 1'b0);
    check("wd_race_state", dbg_state, S_FINISH);
    next_cycle();

    // Reset while ACTIVE, then a fresh command
    accept(4'b0100, 4'b0100, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_owner", owner, 4'b0000);
    check("midrst_state", dbg_state, S_IDLE);
    check_acg_default("midrst_acg");
    accept(4'b1000, 4'b1000, 1'b0);
    check_acg_slice("post_rst_acg", 3);
    finish_cmd(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
